// File: rtl/tpu_mmio_driver.sv
// rtl/tpu_mmio_driver.sv - MMIO sequencer that loads A/B/C into a matrix unit, triggers it and streams C back
//
// Purpose: accepts DIM A rows, DIM B rows and 2*DIM C half-rows from an input
// stream and writes them to the accelerator's MMIO windows. It then pulses the
// MatMul trigger, waits WAIT_CYC cycles, reads the 2*DIM C half-rows back and
// presents them one at a time on a valid/ready output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             one-cycle job start (honoured only when idle)
//   in_data_i/valid_i   operand stream in; in_ready_o high while loading
//   tpu_addr_o/wdata_o  registered MMIO address / write data
//   tpu_rw_o            1 = write, 0 = read or idle
//   tpu_rdata_i         MMIO read data, valid the cycle after the address
//   out_data_o/valid_o  result stream out; out_ready_i is the downstream ready
//   busy_o              high whenever not idle
//   done_o              one-cycle pulse after the last result is taken
module tpu_mmio_driver #(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int WAIT_CYC = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DATAW-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [ADDRW-1:0] tpu_addr_o,
  output logic [DATAW-1:0] tpu_wdata_o,
  output logic             tpu_rw_o,
  input  logic [DATAW-1:0] tpu_rdata_i,
  output logic [DATAW-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int KW  = $clog2(2 * DIM);
  localparam int WCW = $clog2(WAIT_CYC + 1);

  localparam logic [ADDRW-1:0] A_BASE   = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE   = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE   = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] TRIG_ADR = ADDRW'(16'h0400);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_C, TRIG, WAIT, RD_ADDR, RD_CAP, OUT, DONE
  } state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [KW-1:0]    r_q;
  logic [WCW-1:0]   wait_q;
  logic [ADDRW-1:0] tpu_addr_q;
  logic [DATAW-1:0] tpu_wdata_q;
  logic             tpu_rw_q;
  logic [DATAW-1:0] out_data_q;

  logic             loading;
  logic             accept;
  logic             k_last;
  logic             r_last;
  logic [ADDRW-1:0] wr_addr_d;
  logic [ADDRW-1:0] rd_next_d;

  assign loading = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);
  assign accept  = loading && in_valid_i;

  // A and B hold DIM words; C holds twice as many half-rows.
  assign k_last = (state_q == LOAD_C) ? (k_q == KW'(2 * DIM - 1)) : (k_q == KW'(DIM - 1));
  assign r_last = (r_q == KW'(2 * DIM - 1));

  always_comb begin
    wr_addr_d = C_BASE;
    if (state_q == LOAD_A) wr_addr_d = A_BASE;
    else if (state_q == LOAD_B) wr_addr_d = B_BASE;
    wr_addr_d = wr_addr_d + (ADDRW'(k_q) << 3);
  end

  // 16*(r>>1) + 8*(r&1) collapses to 8*r for consecutive half-rows.
  assign rd_next_d = C_BASE + ((ADDRW'(r_q) + ADDRW'(1)) << 3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      r_q         <= '0;
      wait_q      <= '0;
      tpu_addr_q  <= '0;
      tpu_wdata_q <= '0;
      tpu_rw_q    <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // Bus idles at address 0 unless a state below drives or holds it.
      tpu_addr_q  <= '0;
      tpu_wdata_q <= '0;
      tpu_rw_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          k_q <= '0;
          r_q <= '0;
          if (start_i) state_q <= LOAD_A;
        end
        LOAD_A, LOAD_B, LOAD_C: begin
          if (accept) begin
            tpu_addr_q  <= wr_addr_d;
            tpu_wdata_q <= in_data_i;
            tpu_rw_q    <= 1'b1;
            if (k_last) begin
              k_q <= '0;
              if (state_q == LOAD_A) state_q <= LOAD_B;
              else if (state_q == LOAD_B) state_q <= LOAD_C;
              else state_q <= TRIG;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        TRIG: begin
          // The last C write is on the bus this cycle; the trigger follows it.
          tpu_addr_q <= TRIG_ADR;
          wait_q     <= WCW'(WAIT_CYC);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_q == '0) begin
            tpu_addr_q <= C_BASE;
            r_q        <= '0;
            state_q    <= RD_ADDR;
          end else begin
            wait_q <= wait_q - WCW'(1);
          end
        end
        RD_ADDR: begin
          tpu_addr_q <= tpu_addr_q;
          state_q    <= RD_CAP;
        end
        RD_CAP: begin
          tpu_addr_q <= tpu_addr_q;
          out_data_q <= tpu_rdata_i;
          state_q    <= OUT;
        end
        OUT: begin
          if (out_ready_i) begin
            if (r_last) begin
              state_q <= DONE;
            end else begin
              r_q        <= r_q + KW'(1);
              tpu_addr_q <= rd_next_d;
              state_q    <= RD_ADDR;
            end
          end else begin
            tpu_addr_q <= tpu_addr_q;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = loading;
  assign tpu_addr_o  = tpu_addr_q;
  assign tpu_wdata_o = tpu_wdata_q;
  assign tpu_rw_o    = tpu_rw_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = (state_q == OUT);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_tpu_mmio_driver.sv
// tb/tb_tpu_mmio_driver.sv - directed self-checking bench for tpu_mmio_driver
module tb_tpu_mmio_driver;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_wdata;
  logic        tpu_rw;
  logic [63:0] tpu_rdata;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  tpu_mmio_driver dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .tpu_addr_o(tpu_addr), .tpu_wdata_o(tpu_wdata), .tpu_rw_o(tpu_rw),
    .tpu_rdata_i(tpu_rdata),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  int job, cyc, idx, trig_cnt, trig_cyc, viol, done_cnt, stall_cnt;
  bit acc_pend, tog_b, stall3, start_wait;
  logic [15:0] prev_addr, rd_last;
  logic [15:0] wa_q[$];
  logic [63:0] wd_q[$];
  int          wc_q[$];
  logic [15:0] rd_q[$];
  int          rc_q[$];
  logic [63:0] out_q[$];
  logic [63:0] amem [8];
  logic [63:0] bmem [8];
  logic [63:0] cmem [16];
  logic [63:0] res  [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word(input int j, input int i);
    logic [31:0] lo;
    lo = 32'h9E37_79B9 * 32'(i + 1) + 32'(j);
    return {16'hA000 | 16'(j), 16'(i), lo};
  endfunction

  function automatic logic [15:0] exp_wr_addr(input int i);
    if (i < 8) return 16'h0100 + 16'(8 * i);
    if (i < 16) return 16'h0200 + 16'(8 * (i - 8));
    return 16'h0300 + 16'(8 * (i - 16));
  endfunction

  // Toy accelerator: results derived from the written operands at trigger time.
  task automatic compute_res();
    for (int j = 0; j < 16; j++)
      res[j] = cmem[j] + (amem[j >> 1] ^ {bmem[7 - (j >> 1)][31:0], bmem[7 - (j >> 1)][63:32]});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (acc_pend) idx++;
    in_valid  = !(tog_b && idx >= 8 && idx < 16 && cyc[0]);
    in_data   = word(job, idx);
    tpu_rdata = (rd_last >= 16'h0300 && rd_last <= 16'h0378) ? res[int'((rd_last - 16'h0300) >> 3)] : 64'h0;
    out_ready = !(stall3 && out_q.size() == 3 && stall_cnt < 5);
    start     = start_wait && trig_cnt == 1 && cyc == trig_cyc + 5;
    @(negedge clk);
    acc_pend = in_valid && in_ready;
    if (tpu_rw) begin
      wa_q.push_back(tpu_addr);
      wd_q.push_back(tpu_wdata);
      wc_q.push_back(cyc);
      if (tpu_addr >= 16'h0100 && tpu_addr <= 16'h0138) amem[int'((tpu_addr - 16'h0100) >> 3)] = tpu_wdata;
      if (tpu_addr >= 16'h0200 && tpu_addr <= 16'h0238) bmem[int'((tpu_addr - 16'h0200) >> 3)] = tpu_wdata;
      if (tpu_addr >= 16'h0300 && tpu_addr <= 16'h0378) cmem[int'((tpu_addr - 16'h0300) >> 3)] = tpu_wdata;
    end
    if (tpu_addr == 16'h0400) begin
      if (tpu_rw) viol++;
      else begin
        trig_cnt++;
        trig_cyc = cyc;
        compute_res();
      end
    end
    if (!tpu_rw && tpu_addr >= 16'h0300 && tpu_addr <= 16'h0378 && tpu_addr != prev_addr) begin
      rd_q.push_back(tpu_addr);
      rc_q.push_back(cyc);
    end
    rd_last   = tpu_rw ? 16'h0 : tpu_addr;
    prev_addr = tpu_addr;
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (out_valid && !out_ready) begin
      stall_cnt++;
      chk("stall_data", out_data, res[3]);
      chk("stall_addr", 64'(tpu_addr), 64'h0318);
      chk("stall_reads", 64'(rd_q.size()), 64'd4);
    end
    if (done) done_cnt++;
  endtask

  task automatic begin_job(input int j);
    job = j; idx = 0; acc_pend = 1'b0;
    trig_cnt = 0; trig_cyc = 0; viol = 0; done_cnt = 0; stall_cnt = 0;
    prev_addr = 16'h0; rd_last = 16'h0;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    rd_q.delete(); rc_q.delete(); out_q.delete();
    for (int i = 0; i < 8; i++) begin amem[i] = '0; bmem[i] = '0; end
    for (int i = 0; i < 16; i++) begin cmem[i] = '0; res[i] = '0; end
    in_valid = 1'b1;
    in_data  = word(j, 0);
    start    = 1'b1;
  endtask

  task automatic run_job();
    for (int n = 0; n < 400 && done_cnt == 0; n++) cycle();
    repeat (4) cycle();
  endtask

  task automatic check_job();
    chk("n_writes", 64'(wa_q.size()), 64'd32);
    if (wa_q.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("wr_addr[%0d]", i), 64'(wa_q[i]), 64'(exp_wr_addr(i)));
        chk($sformatf("wr_data[%0d]", i), wd_q[i], word(job, i));
      end
      chk("a_span", 64'(wc_q[7] - wc_q[0]), 64'd7);
      chk("b_span", 64'(wc_q[15] - wc_q[8]), tog_b ? 64'd14 : 64'd7);
      chk("c_span", 64'(wc_q[31] - wc_q[16]), 64'd15);
      chk("trig_after_last_wr", 64'(trig_cyc), 64'(wc_q[31] + 1));
    end
    chk("trig_cnt", 64'(trig_cnt), 64'd1);
    chk("rw_at_400", 64'(viol), 64'd0);
    chk("n_reads", 64'(rd_q.size()), 64'd16);
    if (rd_q.size() == 16) begin
      for (int j = 0; j < 16; j++)
        chk($sformatf("rd_addr[%0d]", j), 64'(rd_q[j]), 64'h0300 + 64'(8 * j));
      chk("idle_cycles", 64'(rc_q[0] - trig_cyc - 1), 64'd24);
      if (!stall3) chk("rd_spacing", 64'(rc_q[15] - rc_q[0]), 64'd45);
    end
    chk("n_out", 64'(out_q.size()), 64'd16);
    if (out_q.size() == 16)
      for (int j = 0; j < 16; j++) chk($sformatf("out[%0d]", j), out_q[j], res[j]);
    chk("done_pulses", 64'(done_cnt), 64'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"},  64'(tpu_addr), 64'h0);
    chk({tag, "_wdata"}, tpu_wdata, 64'h0);
    chk({tag, "_rw"},    64'(tpu_rw), 64'h0);
    chk({tag, "_ready"}, 64'(in_ready), 64'h0);
    chk({tag, "_oval"},  64'(out_valid), 64'h0);
    chk({tag, "_odata"}, out_data, 64'h0);
    chk({tag, "_busy"},  64'(busy), 64'h0);
    chk({tag, "_done"},  64'(done), 64'h0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; tpu_rdata = '0;
    tog_b = 1'b0; stall3 = 1'b0; start_wait = 1'b0; cyc = 0; job = 0;
    begin_job(0);
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // in_valid while idle must not be consumed.
    in_valid = 1'b1;
    repeat (4) cycle();
    chk("idle_no_write", 64'(wa_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Full-rate job.
    begin_job(1);
    run_job();
    check_job();

    // Gapped B loading plus a 5-cycle output stall on r=3.
    tog_b = 1'b1; stall3 = 1'b1;
    begin_job(2);
    run_job();
    check_job();
    chk("stall_cycles", 64'(stall_cnt), 64'd5);
    tog_b = 1'b0; stall3 = 1'b0;

    // Stray start while waiting on the accelerator.
    start_wait = 1'b1;
    begin_job(3);
    run_job();
    check_job();
    chk("busy_after_job", 64'(busy), 64'd0);
    start_wait = 1'b0;

    // Reset in LOAD_C with k=5.
    begin_job(4);
    for (int n = 0; n < 300 && idx != 21; n++) cycle();
    chk("reached_c5", 64'(idx), 64'd21);
    chk("c5_trig", 64'(trig_cnt), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh job after reset restarts at A word 0.
    begin_job(5);
    run_job();
    check_job();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
